pattern_seq: RTL and testbench

PATTERN_SEQ -- requirements
Module: pattern_seq

---
 rtl/pattern_seq_pkg.sv | 17 +
 rtl/beat_tick.sv | 37 +++
 rtl/pattern_seq.sv | 140 ++++++++++++++
 tb/tb_pattern_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_seq_pkg.sv
// Shared types and encodings for the pattern sequencer.
package pattern_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Index width with a floor of one bit so single-entry ranges stay legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/beat_tick.sv
// Clocks-per-beat prescaler: counts 0..DIV-1 while enabled, ticks on the last count.
module beat_tick
    import pattern_seq_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o_c
);

    localparam int unsigned CNTW = idx_w(DIV);

    logic [CNTW-1:0] cnt_q, cnt_d;

    assign tick_o_c = en_i && (cnt_q == CNTW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o_c ? '0 : cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pattern_seq.sv
// Multi-channel beat pattern sequencer with double-buffered patterns and
// continuous / one-shot run modes.
module pattern_seq
    import pattern_seq_pkg::*;
#(
    parameter int unsigned BEATS = 8,
    parameter int unsigned CH    = 4,
    parameter int unsigned DIV   = 1,
    localparam int unsigned BW   = $clog2(BEATS),
    localparam int unsigned CW   = idx_w(CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [BW-1:0]    cfg_last,
    input  logic             pat_wr,
    input  logic [CW-1:0]    pat_ch,
    input  logic [BEATS-1:0] pat_data,
    output logic [CH-1:0]    out,
    output logic [BW-1:0]    beat,
    output logic             busy,
    output logic             wrap,
    output logic             done
);

    state_e                     state_q, state_d;
    logic [BW-1:0]              beat_q, beat_d;
    logic [BW-1:0]              last_q, last_d;
    logic                       mode_q, mode_d;
    logic                       wrap_q, wrap_d;
    logic                       done_q, done_d;
    logic [CH-1:0]              out_q, out_d;
    logic [CH-1:0][BEATS-1:0]   shadow_q, shadow_d;
    logic [CH-1:0][BEATS-1:0]   active_q, active_d;
    logic                       tick_c;
    logic                       start_acc_c;
    logic                       leave_c;

    beat_tick #(
        .DIV(DIV)
    ) u_beat_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (state_q == ST_RUN),
        .clr_i    (start_acc_c | leave_c),
        .tick_o_c (tick_c)
    );

    // Next-state, pattern buffering and registered-output decode.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        last_d      = last_q;
        mode_d      = mode_q;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        shadow_d    = shadow_q;
        active_d    = active_q;
        start_acc_c = 1'b0;
        leave_c     = 1'b0;

        for (int c = 0; c < int'(CH); c++) begin
            if (pat_wr && (pat_ch == CW'(c))) begin
                shadow_d[c] = pat_data;
            end
            out_d[c] = (state_q == ST_RUN) ? active_q[c][beat_q] : 1'b0;
        end

        // Copies into active read shadow_q, so a same-cycle write waits for the next copy.
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    start_acc_c = 1'b1;
                    state_d     = ST_RUN;
                    beat_d      = '0;
                    mode_d      = mode;
                    last_d      = cfg_last;
                    active_d    = shadow_q;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    leave_c = 1'b1;
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end else if (tick_c) begin
                    if (beat_q < last_q) begin
                        beat_d = beat_q + BW'(1);
                    end else begin
                        beat_d = '0;
                        if (mode_q == MODE_ONESHOT) begin
                            leave_c = 1'b1;
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            wrap_d   = 1'b1;
                            active_d = shadow_q;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            beat_q   <= '0;
            last_q   <= '0;
            mode_q   <= MODE_CONT;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
            out_q    <= out_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign out  = out_q;
    assign beat = beat_q;
    assign busy = (state_q == ST_RUN);
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_pattern_seq.sv
// Directed bench for pattern_seq: two instances (DIV=1 and DIV=3) share one stimulus.
module tb_pattern_seq;

    logic       clk;
    logic       rst_n;
    logic       start, stop, mode;
    logic [2:0] cfg_last;
    logic       pat_wr;
    logic [0:0] pat_ch;
    logic [7:0] pat_data;

    logic [1:0] o1, o3;
    logic [2:0] bt1, bt3;
    logic       by1, by3, wr1, wr3, dn1, dn3;

    int n_tests = 0;
    int n_fail  = 0;

    pattern_seq #(.BEATS(8), .CH(2), .DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .cfg_last(cfg_last), .pat_wr(pat_wr), .pat_ch(pat_ch), .pat_data(pat_data),
        .out(o1), .beat(bt1), .busy(by1), .wrap(wr1), .done(dn1)
    );

    pattern_seq #(.BEATS(8), .CH(2), .DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
        .cfg_last(cfg_last), .pat_wr(pat_wr), .pat_ch(pat_ch), .pat_data(pat_data),
        .out(o3), .beat(bt3), .busy(by3), .wrap(wr3), .done(dn3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic m, input logic [2:0] l);
        mode = m; cfg_last = l; start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic stop_seq();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
    endtask

    task automatic wr_pat(input logic ch, input logic [7:0] d);
        pat_wr = 1'b1; pat_ch = ch; pat_data = d;
        cyc();
        pat_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) cyc();
        n_tests++; if ({o1, bt1, by1, wr1, dn1} !== 8'h00) begin n_fail++; $display("FAIL reset_d1 got %h exp 00", {o1, bt1, by1, wr1, dn1}); end
        n_tests++; if ({o3, bt3, by3, wr3, dn3} !== 8'h00) begin n_fail++; $display("FAIL reset_d3 got %h exp 00", {o3, bt3, by3, wr3, dn3}); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_continuous();
        logic [7:0] p0, p1;
        logic [1:0] exp_o;
        p0 = 8'hCD; p1 = 8'h0A;
        start_seq(1'b0, 3'd7);
        for (int i = 0; i < 18; i++) begin
            exp_o = (i == 0) ? 2'b00 : {p1[(i-1)%8], p0[(i-1)%8]};
            n_tests++; if (bt1 !== 3'(i % 8)) begin n_fail++; $display("FAIL cont_beat i=%0d got %0d exp %0d", i, bt1, i % 8); end
            n_tests++; if (o1 !== exp_o) begin n_fail++; $display("FAIL cont_out i=%0d got %b exp %b", i, o1, exp_o); end
            n_tests++; if (wr1 !== (i > 0 && i % 8 == 0)) begin n_fail++; $display("FAIL cont_wrap i=%0d got %b", i, wr1); end
            n_tests++; if (by1 !== 1'b1) begin n_fail++; $display("FAIL cont_busy i=%0d got %b exp 1", i, by1); end
            cyc();
        end
        stop_seq();
        n_tests++; if (by1 !== 1'b0) begin n_fail++; $display("FAIL cont_stopped got %b exp 0", by1); end
    endtask

    task automatic test_pattern_update();
        logic [7:0] per [4];
        logic       exp_b;
        per[0] = 8'hCD; per[1] = 8'hFF; per[2] = 8'hFF; per[3] = 8'h00;
        start_seq(1'b0, 3'd7);
        for (int i = 0; i < 27; i++) begin
            exp_b = (i == 0) ? 1'b0 : per[(i-1)/8][(i-1)%8];
            n_tests++; if (o1[0] !== exp_b) begin n_fail++; $display("FAIL upd_out i=%0d got %b exp %b", i, o1[0], exp_b); end
            n_tests++; if (wr1 !== (i > 0 && i % 8 == 0)) begin n_fail++; $display("FAIL upd_wrap i=%0d got %b", i, wr1); end
            pat_wr = 1'b0;
            if (i == 2)  begin pat_wr = 1'b1; pat_ch = 1'b0; pat_data = 8'hFF; end
            if (i == 15) begin pat_wr = 1'b1; pat_ch = 1'b0; pat_data = 8'h00; end
            cyc();
        end
        pat_wr = 1'b0;
        stop_seq();
    endtask

    task automatic test_oneshot();
        logic [7:0] p1;
        logic [1:0] exp_o;
        int         n_done;
        p1 = 8'h0A; n_done = 0;
        start_seq(1'b1, 3'd3);
        for (int i = 0; i < 16; i++) begin
            exp_o = (i >= 1 && i <= 12) ? {p1[(i-1)/3], 1'b0} : 2'b00;
            if (dn3) n_done++;
            n_tests++; if (o3 !== exp_o) begin n_fail++; $display("FAIL os_out i=%0d got %b exp %b", i, o3, exp_o); end
            n_tests++; if (by3 !== (i < 12)) begin n_fail++; $display("FAIL os_busy i=%0d got %b", i, by3); end
            n_tests++; if (dn3 !== (i == 12)) begin n_fail++; $display("FAIL os_done i=%0d got %b", i, dn3); end
            n_tests++; if (bt3 !== ((i < 12) ? 3'(i / 3) : 3'd0)) begin n_fail++; $display("FAIL os_beat i=%0d got %0d", i, bt3); end
            n_tests++; if (dn1 !== (i == 4) || by1 !== (i < 4)) begin n_fail++; $display("FAIL os_div1 i=%0d got done %b busy %b", i, dn1, by1); end
            cyc();
        end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL os_done_count got %0d exp 1", n_done); end
    endtask

    task automatic test_stop();
        logic [7:0] p1;
        logic [1:0] exp_o;
        p1 = 8'h0A;
        wr_pat(1'b0, 8'hFF);
        start_seq(1'b0, 3'd7);
        for (int i = 0; i < 10; i++) begin
            exp_o = (i == 0 || i > 6) ? 2'b00 : {p1[i-1], 1'b1};
            n_tests++; if (o1 !== exp_o) begin n_fail++; $display("FAIL stop_out i=%0d got %b exp %b", i, o1, exp_o); end
            n_tests++; if (by1 !== (i <= 5)) begin n_fail++; $display("FAIL stop_busy i=%0d got %b", i, by1); end
            n_tests++; if (bt1 !== ((i <= 5) ? 3'(i) : 3'd0)) begin n_fail++; $display("FAIL stop_beat i=%0d got %0d", i, bt1); end
            n_tests++; if (dn1 !== 1'b0) begin n_fail++; $display("FAIL stop_done i=%0d got %b exp 0", i, dn1); end
            start = (i == 2);
            if (i == 2) begin mode = 1'b1; cfg_last = 3'd0; end
            stop = (i == 5);
            cyc();
        end
        start = 1'b0; stop = 1'b0;
        start = 1'b1; stop = 1'b1; mode = 1'b0; cfg_last = 3'd7;
        cyc();
        start = 1'b0; stop = 1'b0;
        n_tests++; if (by1 !== 1'b0 || by3 !== 1'b0) begin n_fail++; $display("FAIL startstop_idle got %b%b exp 00", by1, by3); end
        cyc();
        n_tests++; if (by1 !== 1'b0 || o1 !== 2'b00) begin n_fail++; $display("FAIL startstop_hold got busy %b out %b", by1, o1); end
    endtask

    task automatic test_last_zero();
        start_seq(1'b0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            n_tests++; if (wr3 !== (i > 0 && i % 3 == 0)) begin n_fail++; $display("FAIL l0_wrap3 i=%0d got %b", i, wr3); end
            n_tests++; if (wr1 !== (i >= 1)) begin n_fail++; $display("FAIL l0_wrap1 i=%0d got %b", i, wr1); end
            n_tests++; if (bt3 !== 3'd0) begin n_fail++; $display("FAIL l0_beat3 i=%0d got %0d exp 0", i, bt3); end
            n_tests++; if (o1 !== ((i >= 1) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL l0_out1 i=%0d got %b", i, o1); end
            cyc();
        end
        stop_seq();
    endtask

    task automatic test_async_reset();
        start_seq(1'b0, 3'd7);
        repeat (4) cyc();
        n_tests++; if (o1 !== 2'b11) begin n_fail++; $display("FAIL ar_pre_out got %b exp 11", o1); end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if ({o1, bt1, by1, wr1, dn1} !== 8'h00) begin n_fail++; $display("FAIL ar_d1 got %h exp 00", {o1, bt1, by1, wr1, dn1}); end
        n_tests++; if ({o3, bt3, by3, wr3, dn3} !== 8'h00) begin n_fail++; $display("FAIL ar_d3 got %h exp 00", {o3, bt3, by3, wr3, dn3}); end
        cyc();
        rst_n = 1'b1;
        cyc();
        start_seq(1'b0, 3'd7);
        for (int i = 0; i < 10; i++) begin
            n_tests++; if (by1 !== 1'b1 || o1 !== 2'b00) begin n_fail++; $display("FAIL ar_zero i=%0d got busy %b out %b", i, by1, o1); end
            n_tests++; if (bt1 !== 3'(i % 8)) begin n_fail++; $display("FAIL ar_beat i=%0d got %0d exp %0d", i, bt1, i % 8); end
            cyc();
        end
        stop_seq();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; cfg_last = 3'd0;
        pat_wr = 1'b0; pat_ch = 1'b0; pat_data = 8'h00;
        test_reset();
        wr_pat(1'b0, 8'hCD);
        wr_pat(1'b1, 8'h0A);
        test_continuous();
        test_pattern_update();
        test_oneshot();
        test_stop();
        test_last_zero();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
